// File: rtl/pe_packetizer_if.sv
// Packetizer port bundle: PE-side valid/ready word input and router-side 4-phase packet output.
// The packetizer itself connects through the slave modport.
interface pe_packetizer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_type;
    logic [7:0]       in_dst;
    logic [12:0]      in_data;
    logic             out_req;
    logic             out_ack;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] fifo_count;

    modport slave (
        input  in_valid, in_type, in_dst, in_data, out_ack,
        output in_ready, out_req, out_data, fifo_count
    );

    modport master (
        output in_valid, in_type, in_dst, in_data, out_ack,
        input  in_ready, out_req, out_data, fifo_count
    );
endinterface

// File: rtl/pe_packetizer.sv
// Mesh network-interface transmitter: formats PE words into 32-bit packets, buffers them in a FIFO
// and injects them into the router with a 4-phase handshake. Optional macro: PE_PACKETIZER_PARITY_EN.
module pe_packetizer #(
    parameter int         WIDTH_PKT  = 32,
    parameter logic [2:0] ADDRX      = 3'd0,
    parameter logic [4:0] ADDRY      = 5'd0,
    parameter int         FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    pe_packetizer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, REQ, RTZ} state_t;

    state_t               state_q, state_d;
    logic [WIDTH_PKT-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr, count, count_d;
    logic                 in_ready_q;
    logic                 out_req_q, out_req_d;
    logic [WIDTH_PKT-1:0] out_data_q;
    logic                 ack_meta, ack_s;
    logic                 push, pop, empty;

    function automatic logic [WIDTH_PKT-1:0] form_pkt(input logic [1:0]  t,
                                                      input logic [7:0]  dst,
                                                      input logic [12:0] data);
        logic [WIDTH_PKT-1:0] p;
        p = {1'b0, t, dst, ADDRY, ADDRX, data};
`ifdef PE_PACKETIZER_PARITY_EN
        p[31] = ^p[30:0];
`endif
        return p;
    endfunction

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign push    = bus.in_valid && in_ready_q;
    assign count_d = count + PW'(push) - PW'(pop);

    assign bus.in_ready   = in_ready_q;
    assign bus.out_req    = out_req_q;
    assign bus.out_data   = out_data_q;
    assign bus.fifo_count = count;

    // Packet storage holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= form_pkt(bus.in_type, bus.in_dst, bus.in_data);
        end
    end

    // in_ready is registered from next occupancy so it never depends combinationally on in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            in_ready_q <= (count_d != PW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta   <= 1'b0;
            ack_s      <= 1'b0;
            state_q    <= IDLE;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            ack_meta  <= bus.out_ack;
            ack_s     <= ack_meta;
            state_q   <= state_d;
            out_req_q <= out_req_d;
            if (pop) out_data_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    // SETUP gives the router one full cycle of stable data before the request edge.
    always_comb begin
        state_d   = state_q;
        out_req_d = out_req_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                out_req_d = 1'b1;
                state_d   = REQ;
            end
            REQ: begin
                if (ack_s) begin
                    out_req_d = 1'b0;
                    state_d   = RTZ;
                end
            end
            RTZ: begin
                if (!ack_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
